// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer
//   Fetches stereo frames (32-bit words: [31:16] left, [15:0] right) from a
//   frame memory into a small show-ahead FIFO. The FIFO head goes to the
//   codec driver as 24-bit left/right samples, and one frame is consumed per
//   'advance' strobe.
//
//   FSM: IDLE -> REQ -> WAIT -> (REQ | DRAIN) -> IDLE.
//   Only one read is outstanding at a time. mem_addr = base + index and holds
//   steady from mem_rd until mem_valid, because the index only moves on a push.
//
//   Handshake: mem_rd is a one-cycle request issued only from REQ, and only
//   when the FIFO has a free slot. The matching mem_valid is accepted only in
//   WAIT. mem_valid in any other state, or one that arrives after stop or
//   reset, is dropped.
//
//   Build option: define AUDIO_STREAM_LOOP_EN to loop the buffer forever.
//   After the last frame is pushed, the index returns to 0 and the FSM goes
//   back to REQ. DRAIN is then reachable only with length == 0, and playback
//   ends only on stop or reset.
//
//   state_dbg exposes the FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 DRAIN.

module audio_sample_streamer #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    input  logic              advance,
    output logic [23:0]       dac_left,
    output logic [23:0]       dac_right,
    output logic              busy,
    output logic              underrun,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic              load;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [31:0]       head;
    logic              fifo_empty;
    logic              fifo_space;
    logic              push;
    logic              pop;
    logic              flush;
    logic              last_frame;
    logic              underrun_r;

    // FIFO status, the last-frame flag and the outputs derived from them
    always_comb begin
        fifo_empty = (count == '0);
        fifo_space = (count < DEPTH_C);
        last_frame = (idx == (len_r - ADDR_ONE));
        pop        = advance && !fifo_empty;
        head       = fifo_mem[rd_ptr];
        mem_addr   = base_r + idx;
        busy       = (state != S_IDLE);
        underrun   = underrun_r;
        state_dbg  = state;
        dac_left   = fifo_empty ? 24'h0 : {head[31:16], 8'h00};
        dac_right  = fifo_empty ? 24'h0 : {head[15:0], 8'h00};
    end

    // Next-state logic and FSM strobes; stop overrides everything else
    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        mem_rd     = 1'b0;
        push       = 1'b0;
        done       = 1'b0;
        flush      = 1'b0;
        if (stop) begin
            flush      = 1'b1;
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        load       = 1'b1;
                        idx_next   = '0;
                        state_next = (length == '0) ? S_DRAIN : S_REQ;
                    end
                end
                S_REQ: begin
                    if (fifo_space) begin
                        mem_rd     = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        push = 1'b1;
                        if (last_frame) begin
`ifdef AUDIO_STREAM_LOOP_EN
                            idx_next   = '0;
                            state_next = S_REQ;
`else
                            idx_next   = idx + ADDR_ONE;
                            state_next = S_DRAIN;
`endif
                        end else begin
                            idx_next   = idx + ADDR_ONE;
                            state_next = S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register, frame index and the parameters captured on start
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            base_r <= '0;
            len_r  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (load) begin
                base_r <= base_addr;
                len_r  <= length;
            end
        end
    end

    // FIFO pointers and occupancy; a push and a pop together leave count unchanged
    always_ff @(posedge CLOCK_50) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; the contents need no reset because count gates visibility
    always_ff @(posedge CLOCK_50) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end

    // Underrun pulse in the cycle after a starved advance during playback
    always_ff @(posedge CLOCK_50) begin
        if (reset) underrun_r <= 1'b0;
        else       underrun_r <= advance && fifo_empty && busy;
    end

endmodule
